// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer / hazard controller.
package pipe_ctrl_pkg;

  // Encoding matches the externally visible state port.
  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [4:0]  REG_X0   = 5'd0;
  // addi x0, x0, 0 -- what IF/ID holds after a flush.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: instruction in decode reads the register a load in execute writes.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       lu
);

  // x0 is never a real dependency, so a load to x0 never stalls.
  always_comb begin
    lu = ex_mem_read && (ex_rd != REG_X0) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: run/step/halt FSM, per-stage enables, bubble/flush strobes and
// saturating stall/flush counters for the debug display.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step_tick,
  input  logic             halt_req,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             back_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic               adv, lu, stall, flush;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  // Advance qualifier and hazard resolution; a taken branch wins over load-use.
  always_comb begin
    adv   = (state_q != HALT);
    flush = adv && branch_taken;
    stall = adv && lu && !branch_taken;
  end

  // Next-state logic for the sequencer and its drain countdown.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      HALT: begin
        if (run_mode)       state_d = RUN;
        else if (step_tick) state_d = STEP;
      end
      STEP: state_d = HALT;
      RUN: begin
        if (halt_req || !run_mode) begin
          state_d = DRAIN;
          drain_d = DrainW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = HALT;
        else               drain_d = drain_q - DrainW'(1);
      end
      default: state_d = HALT;
    endcase
  end

  // Stage enables and flush strobes, combinational from state and hazards.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    back_en      = adv;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (adv) begin
      pc_en       = (state_q != DRAIN);
      if_id_en    = 1'b1;
      if_id_flush = (state_q == DRAIN);
    end
    if (stall) begin
      // Hold IF/ID so the dependent instruction re-issues, even while draining.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b1;
    end
    if (flush) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HALT;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
